// File: rtl/pep_ldb_blram_feed_if.sv
// pep_ldb_blram_feed_if
//   Bundles the command stream, the wide coefficient stream, the write bus
//   into the key-switch BLWE RAM and the completion pulse.
//   master : the feeder (consumes cmd/in streams, drives the RAM write bus)
//   slave  : the environment (drives cmd/in streams, observes writes/done)
// Ports (all inside the interface):
//   cmd_pid, cmd_pbs_last, cmd_vld, cmd_rdy       : one command per BLWE
//   in_data, in_vld, in_rdy                       : IN_COEF_NB coefs per beat
//   ldb_blram_wr_en/_pid/_data/_pbs_last          : per-subword write bus
//   ldb_done, ldb_done_pid                        : BLWE completion pulse
interface pep_ldb_blram_feed_if #(
  parameter int IN_COEF_NB    = 16,
  parameter int KS_IF_SUBW_NB = 2,
  parameter int KS_IF_COEF_NB = 4,
  parameter int MOD_Q_W       = 32,
  parameter int PID_W         = 6
);
  logic [PID_W-1:0]                                    cmd_pid;
  logic                                                cmd_pbs_last;
  logic                                                cmd_vld;
  logic                                                cmd_rdy;
  logic [IN_COEF_NB*MOD_Q_W-1:0]                       in_data;
  logic                                                in_vld;
  logic                                                in_rdy;
  logic [KS_IF_SUBW_NB-1:0]                            ldb_blram_wr_en;
  logic [KS_IF_SUBW_NB*PID_W-1:0]                      ldb_blram_wr_pid;
  logic [KS_IF_SUBW_NB*KS_IF_COEF_NB*MOD_Q_W-1:0]      ldb_blram_wr_data;
  logic [KS_IF_SUBW_NB-1:0]                            ldb_blram_wr_pbs_last;
  logic                                                ldb_done;
  logic [PID_W-1:0]                                    ldb_done_pid;

  modport master (
    input  cmd_pid, cmd_pbs_last, cmd_vld, in_data, in_vld,
    output cmd_rdy, in_rdy,
    output ldb_blram_wr_en, ldb_blram_wr_pid, ldb_blram_wr_data, ldb_blram_wr_pbs_last,
    output ldb_done, ldb_done_pid
  );

  modport slave (
    output cmd_pid, cmd_pbs_last, cmd_vld, in_data, in_vld,
    input  cmd_rdy, in_rdy,
    input  ldb_blram_wr_en, ldb_blram_wr_pid, ldb_blram_wr_data, ldb_blram_wr_pbs_last,
    input  ldb_done, ldb_done_pid
  );
endinterface

// File: rtl/pep_ldb_blram_feed.sv
// pep_ldb_blram_feed
//   Transmit end of the key-switch BLWE load interface. Accepts one command
//   per BLWE, then serializes the wide coefficient beats of that BLWE into
//   KS_IF_SUBW_NB x KS_IF_COEF_NB write chunks on the ldb_blram_wr_* bus,
//   one chunk per cycle, and pulses ldb_done once the BLWE is written.
// Ports:
//   clk   : clock
//   a_rst : asynchronous reset, active-high
//   bus   : pep_ldb_blram_feed_if.master (cmd stream, data stream, write bus,
//           done pulse)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a command (cmd_rdy=1)
// LOAD  | waiting for the next input beat of the current BLWE (in_rdy=1)
// SER   | the write bus currently shows a valid chunk of the buffered beat
//
// The write-bus registers are loaded one cycle ahead of the SER cycle that
// shows them: accepting a beat loads its chunk 0 straight from in_data, so a
// beat accepted at cycle t is written at t+1, and a beat accepted during the
// last chunk of the previous beat follows without a bubble.
module pep_ldb_blram_feed #(
  parameter int BLWE_COEF_NB  = 2048,
  parameter int IN_COEF_NB    = 16,
  parameter int KS_IF_SUBW_NB = 2,
  parameter int KS_IF_COEF_NB = 4,
  parameter int MOD_Q_W       = 32,
  parameter int PID_W         = 6
) (
  input logic                  clk,
  input logic                  a_rst,
  pep_ldb_blram_feed_if.master bus
);
  localparam int CHUNK_COEF_NB = KS_IF_SUBW_NB * KS_IF_COEF_NB;
  localparam int R             = IN_COEF_NB / CHUNK_COEF_NB;
  localparam int CHUNK_W       = (R > 1) ? $clog2(R) : 1;
  localparam int IDX_W         = $clog2(BLWE_COEF_NB + CHUNK_COEF_NB) + 1;
  localparam int SUBW_DW       = KS_IF_COEF_NB * MOD_Q_W;
  localparam int CHUNK_DW      = CHUNK_COEF_NB * MOD_Q_W;

  localparam logic [IDX_W-1:0]   BLWE_END   = IDX_W'(BLWE_COEF_NB);
  localparam logic [IDX_W-1:0]   CHUNK_STEP = IDX_W'(CHUNK_COEF_NB);
  localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(R - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SER} state_t;

  state_t state, state_nxt;

  logic [PID_W-1:0]                  pid_q;
  logic                              pbs_last_q;
  logic [R-1:0][CHUNK_DW-1:0]        buf_q;
  logic [CHUNK_W-1:0]                chunk_q, chunk_nxt;
  logic [IDX_W-1:0]                  coef_idx_q, coef_idx_nxt;

  logic [KS_IF_SUBW_NB-1:0]          wr_en_q;
  logic [KS_IF_SUBW_NB*PID_W-1:0]    wr_pid_q;
  logic [CHUNK_DW-1:0]               wr_data_q;
  logic [KS_IF_SUBW_NB-1:0]          wr_pbs_last_q;
  logic                              done_q;
  logic [PID_W-1:0]                  done_pid_q;

  logic                              cmd_rdy_c, in_rdy_c;
  logic                              cmd_take, done_set;
  logic [IDX_W-1:0]                  idx_step;
  logic                              ser_blwe_end, ser_beat_end;

  // chunk loader: selects the chunk to present on the write bus next cycle
  logic                              ld_go, ld_from_in;
  logic [CHUNK_W-1:0]                ld_chunk;
  logic [IDX_W-1:0]                  ld_idx;
  logic [R-1:0][CHUNK_DW-1:0]        ld_src;
  logic [CHUNK_DW-1:0]               ld_chunk_data;
  logic [KS_IF_SUBW_NB-1:0]          ld_en;
  logic [CHUNK_DW-1:0]               ld_data;
  logic [KS_IF_SUBW_NB-1:0]          ld_pbs_last;

  always_comb begin
    ld_src        = ld_from_in ? bus.in_data : buf_q;
    ld_chunk_data = ld_src[ld_chunk];
    ld_en         = '0;
    ld_data       = '0;
    ld_pbs_last   = '0;
    // subwords that start past the BLWE end are disabled and zeroed
    for (int j = 0; j < KS_IF_SUBW_NB; j++) begin
      if ((ld_idx + IDX_W'(j * KS_IF_COEF_NB)) < BLWE_END) begin
        ld_en[j]                     = 1'b1;
        ld_data[j*SUBW_DW +: SUBW_DW] = ld_chunk_data[j*SUBW_DW +: SUBW_DW];
      end
    end
    ld_pbs_last[0] = pbs_last_q && ((ld_idx + CHUNK_STEP) >= BLWE_END);
  end

  always_comb begin
    state_nxt    = state;
    cmd_rdy_c    = 1'b0;
    in_rdy_c     = 1'b0;
    cmd_take     = 1'b0;
    done_set     = 1'b0;
    ld_go        = 1'b0;
    ld_from_in   = 1'b0;
    ld_chunk     = '0;
    ld_idx       = coef_idx_q;
    chunk_nxt    = chunk_q;
    coef_idx_nxt = coef_idx_q;
    idx_step     = coef_idx_q + CHUNK_STEP;
    ser_blwe_end = (idx_step >= BLWE_END);
    ser_beat_end = (chunk_q == CHUNK_LAST) || ser_blwe_end;

    case (state)
      IDLE: begin
        cmd_rdy_c = 1'b1;
        if (bus.cmd_vld) begin
          cmd_take     = 1'b1;
          coef_idx_nxt = '0;
          state_nxt    = LOAD;
        end
      end

      LOAD: begin
        in_rdy_c = 1'b1;
        if (bus.in_vld) begin
          ld_go      = 1'b1;
          ld_from_in = 1'b1;
          chunk_nxt  = '0;
          state_nxt  = SER;
        end
      end

      SER: begin
        if (ser_blwe_end) begin
          // final chunk on the bus: done next cycle, next command may start now
          cmd_rdy_c = 1'b1;
          done_set  = 1'b1;
          if (bus.cmd_vld) begin
            cmd_take     = 1'b1;
            coef_idx_nxt = '0;
            state_nxt    = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else if (ser_beat_end) begin
          in_rdy_c     = 1'b1;
          coef_idx_nxt = idx_step;
          if (bus.in_vld) begin
            ld_go      = 1'b1;
            ld_from_in = 1'b1;
            ld_idx     = idx_step;
            chunk_nxt  = '0;
          end else begin
            state_nxt = LOAD;
          end
        end else begin
          ld_go        = 1'b1;
          ld_chunk     = chunk_q + CHUNK_W'(1);
          ld_idx       = idx_step;
          chunk_nxt    = chunk_q + CHUNK_W'(1);
          coef_idx_nxt = idx_step;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      pid_q         <= '0;
      pbs_last_q    <= 1'b0;
      buf_q         <= '0;
      chunk_q       <= '0;
      coef_idx_q    <= '0;
      wr_en_q       <= '0;
      wr_pid_q      <= '0;
      wr_data_q     <= '0;
      wr_pbs_last_q <= '0;
      done_q        <= 1'b0;
      done_pid_q    <= '0;
    end else begin
      chunk_q    <= chunk_nxt;
      coef_idx_q <= coef_idx_nxt;
      done_q     <= done_set;
      if (cmd_take) begin
        pid_q      <= bus.cmd_pid;
        pbs_last_q <= bus.cmd_pbs_last;
      end
      if (ld_go && ld_from_in) buf_q <= bus.in_data;
      // done_pid takes the pid of the BLWE just finished, not the new command
      if (done_set) done_pid_q <= pid_q;
      if (ld_go) begin
        wr_en_q       <= ld_en;
        wr_pid_q      <= {KS_IF_SUBW_NB{pid_q}};
        wr_data_q     <= ld_data;
        wr_pbs_last_q <= ld_pbs_last;
      end else begin
        wr_en_q       <= '0;
        wr_pbs_last_q <= '0;
      end
    end
  end

  // handshake readies are forced low while reset is held
  assign bus.cmd_rdy               = cmd_rdy_c & ~a_rst;
  assign bus.in_rdy                = in_rdy_c & ~a_rst;
  assign bus.ldb_blram_wr_en       = wr_en_q;
  assign bus.ldb_blram_wr_pid      = wr_pid_q;
  assign bus.ldb_blram_wr_data     = wr_data_q;
  assign bus.ldb_blram_wr_pbs_last = wr_pbs_last_q;
  assign bus.ldb_done              = done_q;
  assign bus.ldb_done_pid          = done_pid_q;
endmodule

// File: tb/tb_pep_ldb_blram_feed.sv
module tb_pep_ldb_blram_feed;
  localparam int Q      = 32;
  localparam int PID_W  = 6;
  localparam int SUBW   = 2;
  localparam int COEF   = 4;
  localparam int IN_NB  = 16;
  localparam int S_BLWE = 20;
  localparam int D_BLWE = 2048;
  localparam int CW     = SUBW * COEF;
  localparam int IN_W   = IN_NB * Q;
  localparam int WR_DW  = CW * Q;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s, rst_d;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  pep_ldb_blram_feed_if #(.IN_COEF_NB(IN_NB), .KS_IF_SUBW_NB(SUBW), .KS_IF_COEF_NB(COEF),
                          .MOD_Q_W(Q), .PID_W(PID_W)) bs ();
  pep_ldb_blram_feed_if #(.IN_COEF_NB(IN_NB), .KS_IF_SUBW_NB(SUBW), .KS_IF_COEF_NB(COEF),
                          .MOD_Q_W(Q), .PID_W(PID_W)) bd ();

  pep_ldb_blram_feed #(.BLWE_COEF_NB(S_BLWE), .IN_COEF_NB(IN_NB), .KS_IF_SUBW_NB(SUBW),
                       .KS_IF_COEF_NB(COEF), .MOD_Q_W(Q), .PID_W(PID_W))
    dut_s (.clk(clk), .a_rst(rst_s), .bus(bs));

  pep_ldb_blram_feed #(.BLWE_COEF_NB(D_BLWE), .IN_COEF_NB(IN_NB), .KS_IF_SUBW_NB(SUBW),
                       .KS_IF_COEF_NB(COEF), .MOD_Q_W(Q), .PID_W(PID_W))
    dut_d (.clk(clk), .a_rst(rst_d), .bus(bd));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [SUBW-1:0]  en;
    logic [WR_DW-1:0] data;
    logic [PID_W-1:0] pid;
    logic             last;
    bit               gap_chk;
  } wr_t;

  wr_t              exp_q[$];
  logic [PID_W-1:0] done_q[$];
  wr_t              e_s;

  // coefficient k of a BLWE loaded with base b carries the value b+k
  function automatic logic [IN_W-1:0] beat(input int base, input int b);
    logic [IN_W-1:0] v;
    for (int i = 0; i < IN_NB; i++) v[i*Q +: Q] = Q'(base + b*IN_NB + i);
    return v;
  endfunction

  task automatic push_blwe(input logic [PID_W-1:0] pid, input logic last, input int base,
                           input bit gap_chk);
    wr_t e;
    for (int c = 0; c < S_BLWE; c += CW) begin
      e.en   = '0;
      e.data = '0;
      for (int j = 0; j < SUBW; j++) begin
        if (c + j*COEF < S_BLWE) begin
          e.en[j] = 1'b1;
          for (int k = 0; k < COEF; k++) e.data[(j*COEF+k)*Q +: Q] = Q'(base + c + j*COEF + k);
        end
      end
      e.pid     = pid;
      e.last    = last && (c + CW >= S_BLWE);
      e.gap_chk = gap_chk && (c == 0);
      exp_q.push_back(e);
    end
    done_q.push_back(pid);
  endtask

  // small-config monitor / scoreboard
  int beats_s = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  always @(posedge clk) if (bs.in_vld && bs.in_rdy) beats_s++;

  always @(negedge clk) begin
    if (!rst_s) begin
      if (bs.ldb_blram_wr_en != '0) begin
        if (exp_q.size() == 0) begin
          check("unexp_wr", bs.ldb_blram_wr_en, '0);
        end else begin
          e_s = exp_q.pop_front();
          check("wr_en", bs.ldb_blram_wr_en, e_s.en);
          check("wr_data", bs.ldb_blram_wr_data, e_s.data);
          check("wr_pid", bs.ldb_blram_wr_pid, {SUBW{e_s.pid}});
          check("wr_pbs_last", bs.ldb_blram_wr_pbs_last, {1'b0, e_s.last});
          if (e_s.gap_chk) check("b2b_gap_le2", (cyc - done_cyc) <= 2, 1);
        end
        last_wr_cyc = cyc;
      end else begin
        check("pbs_last_idle", bs.ldb_blram_wr_pbs_last, '0);
      end
      if (bs.ldb_done) begin
        if (done_q.size() == 0) check("unexp_done", bs.ldb_done, 0);
        else begin
          check("done_pid", bs.ldb_done_pid, done_q.pop_front());
          check("done_lat", cyc - last_wr_cyc, 1);
        end
        done_cyc = cyc;
      end
    end
  end

  // default-config monitor
  int wr_cnt_d = 0, pbs_cnt_d = 0, beats_d = 0;
  bit done_seen_d = 0;
  function automatic logic [WR_DW-1:0] d_exp(input int w);
    logic [WR_DW-1:0] v;
    for (int i = 0; i < CW; i++) v[i*Q +: Q] = Q'(w*CW + i);
    return v;
  endfunction

  always @(posedge clk) if (bd.in_vld && bd.in_rdy) beats_d++;

  always @(negedge clk) begin
    if (!rst_d) begin
      if (bd.ldb_blram_wr_en != '0) begin
        check("d_wr_en", bd.ldb_blram_wr_en, 2'b11);
        check("d_wr_data", bd.ldb_blram_wr_data, d_exp(wr_cnt_d));
        if (bd.ldb_blram_wr_pbs_last[0]) begin
          pbs_cnt_d++;
          check("d_pbs_last_pos", wr_cnt_d, D_BLWE/CW - 1);
        end
        wr_cnt_d++;
      end
      if (bd.ldb_done) begin
        done_seen_d = 1;
        check("d_done_pid", bd.ldb_done_pid, 33);
      end
    end
  end

  task automatic s_cmd(input logic [PID_W-1:0] pid, input logic last);
    int n = 0;
    bs.cmd_pid = pid; bs.cmd_pbs_last = last; bs.cmd_vld = 1'b1;
    while (!bs.cmd_rdy && n < 200) begin @(negedge clk); n++; end
    check("cmd_wait", n < 200, 1);
    @(negedge clk);
    bs.cmd_vld = 1'b0;
  endtask

  task automatic s_beat(input logic [IN_W-1:0] d);
    int n = 0;
    bs.in_data = d; bs.in_vld = 1'b1;
    while (!bs.in_rdy && n < 200) begin @(negedge clk); n++; end
    check("beat_wait", n < 200, 1);
    @(negedge clk);
    bs.in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 500) begin @(negedge clk); n++; end
    check("drain_wait", n < 500, 1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bs.cmd_pid = '0; bs.cmd_pbs_last = 1'b0; bs.cmd_vld = 1'b0; bs.in_data = '0; bs.in_vld = 1'b0;
    bd.cmd_pid = '0; bd.cmd_pbs_last = 1'b0; bd.cmd_vld = 1'b0; bd.in_data = '0; bd.in_vld = 1'b0;
    rst_s = 1'b1; rst_d = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr_en", bs.ldb_blram_wr_en, '0);
    check("rst_wr_data", bs.ldb_blram_wr_data, '0);
    check("rst_done", bs.ldb_done, 0);
    check("rst_cmd_rdy", bs.cmd_rdy, 0);
    rst_s = 1'b0; rst_d = 1'b0;
    @(negedge clk);
    check("idle_cmd_rdy", bs.cmd_rdy, 1);
    check("idle_in_rdy", bs.in_rdy, 0);

    // basic BLWE, continuous data, trailing coefs discarded
    push_blwe(5, 1'b1, 0, 0);
    s_cmd(5, 1'b1);
    s_beat(beat(0, 0));
    check("first_wr_lat", bs.ldb_blram_wr_en, 2'b11);
    s_beat(beat(0, 1));
    wait_drain();

    // stall between beats
    push_blwe(7, 1'b0, 'h100, 0);
    s_cmd(7, 1'b0);
    s_beat(beat('h100, 0));
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check("stall_wr_en", bs.ldb_blram_wr_en, '0);
      check("stall_in_rdy", bs.in_rdy, 1);
    end
    s_beat(beat('h100, 1));
    wait_drain();

    // back-to-back commands
    push_blwe(1, 1'b0, 'h200, 0);
    push_blwe(2, 1'b1, 'h300, 1);
    fork
      begin s_cmd(1, 1'b0); s_cmd(2, 1'b1); end
      begin
        s_beat(beat('h200, 0)); s_beat(beat('h200, 1));
        s_beat(beat('h300, 0)); s_beat(beat('h300, 1));
      end
    join
    wait_drain();

    // reset in the middle of serialization
    push_blwe(3, 1'b1, 'h400, 0);
    s_cmd(3, 1'b1);
    s_beat(beat('h400, 0));
    bs.in_data = beat('h400, 1); bs.in_vld = 1'b1;
    @(negedge clk);
    #1;
    rst_s = 1'b1;
    exp_q.delete();
    done_q.delete();
    #1;
    check("arst_wr_en", bs.ldb_blram_wr_en, '0);
    check("arst_wr_data", bs.ldb_blram_wr_data, '0);
    check("arst_wr_pid", bs.ldb_blram_wr_pid, '0);
    check("arst_done", bs.ldb_done, 0);
    check("arst_in_rdy", bs.in_rdy, 0);
    bs.in_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_done", bs.ldb_done, 0);
    end
    push_blwe(9, 1'b1, 'h500, 0);
    s_cmd(9, 1'b1);
    s_beat(beat('h500, 0));
    s_beat(beat('h500, 1));
    wait_drain();

    // in_vld while idle without a command
    n = beats_s;
    bs.in_data = beat('h600, 0); bs.in_vld = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_vld_in_rdy", bs.in_rdy, 0);
      check("idle_vld_wr_en", bs.ldb_blram_wr_en, '0);
    end
    check("idle_vld_no_consume", beats_s - n, 0);
    push_blwe(11, 1'b0, 'h600, 0);
    s_cmd(11, 1'b0);
    s_beat(beat('h600, 0));
    s_beat(beat('h600, 1));
    wait_drain();
    check("s_beats_total", beats_s, 13);

    // default parameters: one full BLWE
    bd.cmd_pid = 6'd33; bd.cmd_pbs_last = 1'b1; bd.cmd_vld = 1'b1;
    n = 0;
    while (!bd.cmd_rdy && n < 50) begin @(negedge clk); n++; end
    check("d_cmd_wait", n < 50, 1);
    @(negedge clk);
    bd.cmd_vld = 1'b0;
    for (int b = 0; b < D_BLWE/IN_NB; b++) begin
      bd.in_data = beat(0, b); bd.in_vld = 1'b1;
      n = 0;
      while (!bd.in_rdy && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("d_beat_wait", n < 50, 1);
      @(negedge clk);
      bd.in_vld = 1'b0;
    end
    n = 0;
    while (!done_seen_d && n < 100) begin @(negedge clk); n++; end
    check("d_done_seen", done_seen_d, 1);
    @(negedge clk);
    check("d_wr_count", wr_cnt_d, D_BLWE/CW);
    check("d_beats", beats_d, D_BLWE/IN_NB);
    check("d_pbs_count", pbs_cnt_d, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
